fs_gen: RTL and testbench

Parametrised successor to the fixed 13-bit frequency selector. A reloadable up-counter divides clk by (2^DIV_W − sw) and emits a carry pulse `co`. Each `co` advances a phase accumulator by `phase_cnt`. A registered shaper converts the accumulator into sawtooth, triangle, square (programmable duty) or DC output on `wave`. The block feeds the lab DAC/waveform output path.

---
 rtl/fs_pkg.sv | 22 ++
 rtl/fs_div.sv | 40 ++++
 rtl/fs_gen.sv | 76 +++++++
 tb/tb_fs_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// Shared definitions for the frequency selector / waveform generator:
// waveform mode encodings and the default widths used by fs_gen.
package fs_pkg;

  // Default divider width; the divide ratio is 2^FS_DIV_W - sw.
  localparam int FS_DIV_W   = 13;

  // Default output sample width; the phase accumulator is one bit wider.
  localparam int FS_WAVE_W  = 8;

  // Default phase step width.
  localparam int FS_PHASE_W = 8;

  // Waveform shaper selection, as driven on the mode input.
  typedef enum logic [1:0] {
    MODE_SAW = 2'b00,
    MODE_TRI = 2'b01,
    MODE_SQR = 2'b10,
    MODE_DC  = 2'b11
  } fs_mode_t;

endpackage : fs_pkg

// File: rtl/fs_div.sv
// Reloadable up-counter clock divider. Counts from sw up to all-ones and
// emits a one-cycle registered carry each time it wraps back to sw, giving
// a period of 2^DIV_W - sw cycles. sw is only looked at while disabled or
// at the reload point, so a mid-period change never shortens a period.
module fs_div
  import fs_pkg::*;
#(
  parameter int DIV_W = FS_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] sw,
  output logic             co
);

  logic [DIV_W-1:0] cnt;
  logic             at_top;

  // The counter has reached its terminal value and reloads on this edge.
  assign at_top = (cnt == {DIV_W{1'b1}});

  // Counter with reload at terminal count; carry registered alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      co  <= 1'b0;
    end else if (!en) begin
      cnt <= sw;
      co  <= 1'b0;
    end else if (at_top) begin
      cnt <= sw;
      co  <= 1'b1;
    end else begin
      cnt <= cnt + DIV_W'(1);
      co  <= 1'b0;
    end
  end

endmodule : fs_div

// File: rtl/fs_gen.sv
// Frequency selector / waveform generator. The divider carry steps a
// WAVE_W+1 bit phase accumulator by phase_cnt; a registered shaper turns
// the accumulator into a sawtooth, triangle, square or DC sample.
// PHASE_W must not exceed WAVE_W+1 (the step is zero-extended).
module fs_gen
  import fs_pkg::*;
#(
  parameter int DIV_W   = FS_DIV_W,
  parameter int WAVE_W  = FS_WAVE_W,
  parameter int PHASE_W = FS_PHASE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DIV_W-1:0]   sw,
  input  logic [PHASE_W-1:0] phase_cnt,
  input  logic               phase_clr,
  input  logic [1:0]         mode,
  input  logic [WAVE_W-1:0]  duty,
  output logic               co,
  output logic [WAVE_W-1:0]  wave
);

  localparam int ACC_W = WAVE_W + 1;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  phase_ext;
  logic [WAVE_W-1:0] acc_low;
  logic [WAVE_W-1:0] shaped;

  assign phase_ext = ACC_W'(phase_cnt);
  assign acc_low   = acc[WAVE_W-1:0];

  fs_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .sw  (sw),
    .co  (co)
  );

  // Phase accumulator: a clear wins over the carry-driven step, wraps mod 2^ACC_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (phase_clr) begin
      acc <= '0;
    end else if (co) begin
      acc <= acc + phase_ext;
    end
  end

  // Waveform shaping from the current phase, mode and duty setting.
  always_comb begin
    shaped = '0;
    case (mode)
      MODE_SAW: shaped = acc_low;
      MODE_TRI: shaped = acc[WAVE_W] ? ~acc_low : acc_low;
      MODE_SQR: shaped = (acc_low < duty) ? {WAVE_W{1'b1}} : {WAVE_W{1'b0}};
      MODE_DC:  shaped = duty;
      default:  shaped = '0;
    endcase
  end

  // Output sample register, one cycle behind the accumulator/controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wave <= '0;
    end else begin
      wave <= shaped;
    end
  end

endmodule : fs_gen

// File: tb/tb_fs_gen.sv
// Scoreboard bench for fs_gen: stimulus pushes expected carry periods and
// expected sample values into queues; a negedge monitor pops and compares
// them against what the design presents.
module tb_fs_gen;
  import fs_pkg::*;

  localparam int SIG_WAVE = 0;
  localparam int SIG_CO   = 1;
  localparam int SIG_ACC  = 2;
  localparam int SIG_HI   = 3;
  localparam int SIG_LO   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [12:0] sw = '0;
  logic [7:0]  phase_cnt = '0;
  logic        phase_clr = 1'b0;
  logic [1:0]  mode = MODE_SAW;
  logic [7:0]  duty = '0;
  logic        co;
  logic [7:0]  wave;

  typedef struct {
    string name;
    int    sig;
    int    exp;
  } check_t;

  check_t checkQ[$];
  int     periodQ[$];
  int     compared = 0;
  int     mismatched = 0;
  int     cyc = 0;
  int     lastCo = 0;
  bit     windowOn = 1'b0;
  int     hiCnt = 0;
  int     loCnt = 0;
  check_t monItem;
  int     monAct;
  int     monPeriod;

  fs_gen #(
    .DIV_W   (13),
    .WAVE_W  (8),
    .PHASE_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sw        (sw),
    .phase_cnt (phase_cnt),
    .phase_clr (phase_clr),
    .mode      (mode),
    .duty      (duty),
    .co        (co),
    .wave      (wave)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Free-running cycle index used to measure carry spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pushCheck(input string name, input int sig, input int exp);
    check_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    checkQ.push_back(c);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [12:0] swV, input logic [7:0] pcV,
                               input logic [1:0] modeV, input logic [7:0] dutyV);
    en        = 1'b0;
    sw        = swV;
    phase_cnt = pcV;
    mode      = modeV;
    duty      = dutyV;
    phase_clr = 1'b1;
    waitCycles(1);
    phase_clr = 1'b0;
    waitCycles(1);
  endtask

  // Monitor: window counting, carry-period scoreboard, queued sample checks.
  always @(negedge clk) begin
    if (windowOn) begin
      if (wave == 8'hFF) hiCnt++;
      else if (wave == 8'h00) loCnt++;
    end
    if (co === 1'b1) begin
      if (periodQ.size() > 0) begin
        monPeriod = periodQ.pop_front();
        checkOutput("coPeriod", cyc - lastCo, monPeriod);
      end
      lastCo = cyc;
    end
    while (checkQ.size() > 0) begin
      monItem = checkQ.pop_front();
      case (monItem.sig)
        SIG_WAVE: monAct = int'(wave);
        SIG_CO:   monAct = int'(co);
        SIG_ACC:  monAct = int'(dut.acc);
        SIG_HI:   monAct = hiCnt;
        default:  monAct = loCnt;
      endcase
      checkOutput(monItem.name, monAct, monItem.exp);
    end
  end

  initial begin
    // Reset state while rst is held low.
    pushCheck("resetCo", SIG_CO, 0);
    pushCheck("resetWave", SIG_WAVE, 0);
    pushCheck("resetAcc", SIG_ACC, 0);
    #20;
    rst = 1'b1;
    waitCycles(1);

    // Period 6145 with sw=0x07FF, wave steps by one per carry.
    $display("[TB] period check");
    applyStimulus(13'h07FF, 8'd1, MODE_SAW, 8'd0);
    repeat (3) periodQ.push_back(6145);
    lastCo = cyc;
    en = 1'b1;
    waitCycles(6150);
    pushCheck("sawStep1", SIG_WAVE, 1);
    waitCycles(6145);
    pushCheck("sawStep2", SIG_WAVE, 2);
    waitCycles(6145);
    pushCheck("sawStep3", SIG_WAVE, 3);
    pushCheck("accStep3", SIG_ACC, 3);
    en = 1'b0;

    // 52 carries of step 5 -> acc 260; saw 4, triangle 251, then DC.
    $display("[TB] saw/triangle check");
    applyStimulus(13'h1FFE, 8'd5, MODE_SAW, 8'd0);
    repeat (52) periodQ.push_back(2);
    lastCo = cyc;
    en = 1'b1;
    waitCycles(104);
    en = 1'b0;
    waitCycles(3);
    pushCheck("acc260", SIG_ACC, 260);
    pushCheck("saw260", SIG_WAVE, 4);
    mode = MODE_TRI;
    waitCycles(1);
    pushCheck("tri260", SIG_WAVE, 251);
    pushCheck("accAfterMode", SIG_ACC, 260);
    mode = MODE_DC;
    duty = 8'h5A;
    waitCycles(1);
    pushCheck("dcLevel", SIG_WAVE, 8'h5A);

    // Square wave at duty 64 over a full 256-sample phase sweep, then duty 0.
    $display("[TB] square duty check");
    applyStimulus(13'h1FFF, 8'd1, MODE_SQR, 8'd64);
    repeat (3) periodQ.push_back(1);
    lastCo = cyc;
    en = 1'b1;
    waitCycles(4);
    hiCnt = 0;
    loCnt = 0;
    windowOn = 1'b1;
    waitCycles(256);
    windowOn = 1'b0;
    pushCheck("sqrHigh64", SIG_HI, 64);
    pushCheck("sqrLow64", SIG_LO, 192);
    duty = 8'd0;
    waitCycles(2);
    hiCnt = 0;
    loCnt = 0;
    windowOn = 1'b1;
    waitCycles(32);
    windowOn = 1'b0;
    pushCheck("sqrHighDuty0", SIG_HI, 0);
    pushCheck("sqrLowDuty0", SIG_LO, 32);
    en = 1'b0;

    // sw change half way through a 16-cycle period applies from the next one.
    $display("[TB] sw change check");
    applyStimulus(13'h1FF0, 8'd1, MODE_SAW, 8'd0);
    periodQ.push_back(16);
    repeat (3) periodQ.push_back(4);
    lastCo = cyc;
    en = 1'b1;
    waitCycles(8);
    sw = 13'h1FFC;
    waitCycles(20);
    en = 1'b0;

    // Wrap: 3 x 0xFF = 765 -> 253; then clear on a carry cycle.
    $display("[TB] wrap and clear check");
    applyStimulus(13'h1FFE, 8'hFF, MODE_SAW, 8'd0);
    repeat (3) periodQ.push_back(2);
    lastCo = cyc;
    en = 1'b1;
    waitCycles(6);
    en = 1'b0;
    waitCycles(2);
    pushCheck("accWrap", SIG_ACC, 253);
    pushCheck("sawWrap", SIG_WAVE, 253);
    periodQ.push_back(2);
    lastCo = cyc;
    en = 1'b1;
    waitCycles(2);
    phase_clr = 1'b1;
    pushCheck("coWithClr", SIG_CO, 1);
    waitCycles(1);
    phase_clr = 1'b0;
    pushCheck("accClrOnCo", SIG_ACC, 0);
    pushCheck("coAfterClr", SIG_CO, 0);
    en = 1'b0;

    // Reset between carries, then first carry 8192 cycles after release.
    $display("[TB] mid-run reset check");
    applyStimulus(13'h1FF0, 8'd3, MODE_SAW, 8'd0);
    repeat (2) periodQ.push_back(16);
    lastCo = cyc;
    en = 1'b1;
    waitCycles(40);
    pushCheck("waveBeforeRst", SIG_WAVE, 6);
    pushCheck("accBeforeRst", SIG_ACC, 6);
    waitCycles(1);
    #1;
    rst = 1'b0;
    pushCheck("rstCo", SIG_CO, 0);
    pushCheck("rstWave", SIG_WAVE, 0);
    pushCheck("rstAcc", SIG_ACC, 0);
    waitCycles(2);
    rst = 1'b1;
    periodQ.push_back(8192);
    periodQ.push_back(16);
    lastCo = cyc;
    waitCycles(8212);
    pushCheck("accAfterRst", SIG_ACC, 6);
    waitCycles(1);
    en = 1'b0;
    waitCycles(2);

    // Any carry period still queued never arrived.
    while (periodQ.size() > 0) begin
      checkOutput("coMissing", -1, periodQ.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_fs_gen
